// File: rtl/input_debouncer_pkg.sv
// input_debouncer_pkg: shared state encoding and parameter defaults for the debouncer.
package input_debouncer_pkg;
    typedef enum logic [1:0] {STABLE_LO, CHK_HI, STABLE_HI, CHK_LO} db_state_t;
    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 50000;
    localparam int CNT_WIDTH_DEF       = 16;
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one synchroniser plus counter FSM producing a clean level and edge pulses.
module debounce_channel
    import input_debouncer_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_WIDTH       = CNT_WIDTH_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_clean,
    output logic o_rise,
    output logic o_fall,
    output logic o_busy
);
    logic [SYNC_STAGES-1:0] sync_q;
    db_state_t              state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   clean_q, clean_d, rise_q, rise_d, fall_q, fall_d;
    logic                   s, accept;

    assign s      = sync_q[SYNC_STAGES-1];
    assign accept = cnt_q == CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q  <= '0;
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], i_raw};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // cnt tracks consecutive cycles where the synchronised input disagrees with the clean level
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        clean_d = clean_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            STABLE_LO: if (s) begin
                state_d = CHK_HI;
                cnt_d   = CNT_WIDTH'(1);
            end
            CHK_HI: if (!s) begin
                state_d = STABLE_LO;
            end else if (accept) begin
                state_d = STABLE_HI;
                clean_d = 1'b1;
                rise_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            STABLE_HI: if (!s) begin
                state_d = CHK_LO;
                cnt_d   = CNT_WIDTH'(1);
            end
            CHK_LO: if (s) begin
                state_d = STABLE_HI;
            end else if (accept) begin
                state_d = STABLE_LO;
                clean_d = 1'b0;
                fall_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            default: state_d = STABLE_LO;
        endcase
    end

    assign o_clean = clean_q;
    assign o_rise  = rise_q;
    assign o_fall  = fall_q;
    assign o_busy  = (state_q == CHK_HI) || (state_q == CHK_LO);
endmodule

// File: rtl/input_debouncer.sv
// input_debouncer: N_CH independent debounced channels with a shared busy indication.
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int N_CH            = 2,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_WIDTH       = CNT_WIDTH_DEF
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [N_CH-1:0] i_raw,
    output logic [N_CH-1:0] o_clean,
    output logic [N_CH-1:0] o_rise,
    output logic [N_CH-1:0] o_fall,
    output logic            o_busy
);
    logic [N_CH-1:0] busy;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_WIDTH      (CNT_WIDTH)
        ) u_ch (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .i_raw  (i_raw[g]),
            .o_clean(o_clean[g]),
            .o_rise (o_rise[g]),
            .o_fall (o_fall[g]),
            .o_busy (busy[g])
        );
    end

    assign o_busy = |busy;
endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: directed stimulus with a pulse scoreboard checked by an independent monitor.
module tb_input_debouncer;
    localparam int LAT = 6;
    typedef struct {
        int         cyc;
        logic [1:0] rise;
        logic [1:0] fall;
        logic [1:0] clean;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] raw = 2'b00;
    logic [1:0] clean, rise, fall;
    logic       busy;
    int         cyc = 0;
    int         passed = 0;
    int         total = 0;
    ev_t        exp_q[$];

    input_debouncer #(.N_CH(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_WIDTH(3)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_raw  (raw),
        .o_clean(clean),
        .o_rise (rise),
        .o_fall (fall),
        .o_busy (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
    endtask

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_ev(logic [1:0] r, logic [1:0] f, logic [1:0] c);
        ev_t e;
        e.cyc = cyc + LAT; e.rise = r; e.fall = f; e.clean = c;
        exp_q.push_back(e);
    endtask

    // Monitor: every pulse must match the head of the scoreboard; overdue entries are misses
    always @(negedge clk) begin
        if ((rise & fall) != 2'b00) begin
            total++;
            $display("FAIL rise_fall_overlap cyc=%0d rise=%b fall=%b", cyc, rise, fall);
        end
        if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
            total++;
            $display("FAIL missed_pulse exp_cyc=%0d now=%0d rise=%b fall=%b", exp_q[0].cyc, cyc, exp_q[0].rise, exp_q[0].fall);
            void'(exp_q.pop_front());
        end
        if ((rise | fall) != 2'b00) begin
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_pulse cyc=%0d rise=%b fall=%b clean=%b", cyc, rise, fall, clean);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (e.cyc == cyc && e.rise === rise && e.fall === fall && e.clean === clean) passed++;
                else $display("FAIL pulse cyc=%0d/%0d rise=%b/%b fall=%b/%b clean=%b/%b (got/exp)",
                              cyc, e.cyc, rise, e.rise, fall, e.fall, clean, e.clean);
            end
        end
    end

    initial begin
        step(3);
        rst = 1'b0;
        chk("reset_state", {1'b0, clean, rise, fall, busy}, 8'h00);
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk("idle_quiet", {1'b0, clean, rise, fall, busy}, 8'h00);
        end
        // single rise on channel 0
        raw = 2'b01;
        expect_ev(2'b01, 2'b00, 2'b01);
        step(4);
        chk("busy_during_check", {7'd0, busy}, 8'd1);
        chk("ch1_untouched", {7'd0, clean[1]}, 8'd0);
        step(3);
        chk("clean_after_rise", {6'd0, clean}, 8'h01);
        chk("busy_after_rise", {7'd0, busy}, 8'd0);
        raw = 2'b00;
        expect_ev(2'b00, 2'b01, 2'b00);
        step(10);
        chk("clean_after_fall", {6'd0, clean}, 8'h00);
        // 3-cycle glitch on channel 1 is rejected one edge before acceptance
        raw = 2'b10;
        step(3);
        raw = 2'b00;
        step(10);
        chk("glitch_rejected", {6'd0, clean}, 8'h00);
        chk("glitch_busy_clear", {7'd0, busy}, 8'd0);
        // simultaneous change on both channels
        raw = 2'b11;
        expect_ev(2'b11, 2'b00, 2'b11);
        step(10);
        chk("both_high", {6'd0, clean}, 8'h03);
        raw = 2'b00;
        expect_ev(2'b00, 2'b11, 2'b00);
        step(10);
        chk("both_low", {6'd0, clean}, 8'h00);
        // reset aborts a check in progress; held input restarts from reset release
        raw = 2'b01;
        step(3);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("after_midreset", {1'b0, clean, rise, fall, busy}, 8'h00);
        expect_ev(2'b01, 2'b00, 2'b01);
        step(10);
        chk("rise_after_midreset", {6'd0, clean}, 8'h01);
        raw = 2'b00;
        expect_ev(2'b00, 2'b01, 2'b00);
        step(10);
        // bounce every 2 cycles never reaches acceptance
        for (int i = 0; i < 10; i++) begin
            raw[0] = ~raw[0];
            step(2);
        end
        chk("bounce_no_change", {6'd0, clean}, 8'h00);
        raw = 2'b01;
        expect_ev(2'b01, 2'b00, 2'b01);
        step(12);
        chk("settled_high", {6'd0, clean}, 8'h01);
        chk("scoreboard_drained", 8'(exp_q.size()), 8'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
